// File: rtl/proc_pkg.sv
// proc_pkg
// Shared definitions for the bus-based processor control path.
//   OP_*     : 3-bit opcode constants (101..111 are reserved and run as NOP)
//   step_t   : control step enumeration T0..T3
//   MUX_G    : bus-select bit index of the G register
//   MUX_DIN  : bus-select bit index of the external DIN word
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  // The bus select vector places the general registers first, then G, then DIN.
  function automatic int MUX_G(input int num_regs);
    return num_regs;
  endfunction

  function automatic int MUX_DIN(input int num_regs);
    return num_regs + 1;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// onehot_decoder
// Binary-to-one-hot decoder with enable.
//   SEL    in  IN_W       binary index
//   EN     in  1          when 0 the output is all zero
//   ONEHOT out 2**IN_W    one-hot image of SEL
module onehot_decoder #(
  parameter int IN_W = 3
) (
  input  logic [IN_W-1:0]      SEL,
  input  logic                 EN,
  output logic [(1<<IN_W)-1:0] ONEHOT
);

  always_comb begin
    ONEHOT = '0;
    if (EN) ONEHOT[SEL] = 1'b1;
  end

endmodule

// File: rtl/proc_control_unit.sv
// proc_control_unit
// Four-step control sequencer for the simple bus-based processor. Fetches on
// RUN in T0, then decodes IRLINE to drive the bus mux, register loads, the
// A/G accumulator loads and the add/subtract mode. Outputs are a
// combinational decode of the current step and the instruction.
//   CLOCK        in  1            rising-edge clock
//   RESET        in  1            synchronous active-high reset
//   RUN          in  1            start request, honoured in T0 only
//   ZFLAG        in  1            G == 0, consulted by mvnz in T1
//   IRLINE       in  IR_W         {opcode, X, Y}
//   MUXLINE      out NUM_REGS+2   one-hot bus select {DIN, G, R[n-1..0]}
//   REGSELECTORS out NUM_REGS     one-hot general register load enable
//   IREN         out 1            IR load enable
//   AEN          out 1            A load enable
//   GEN          out 1            G load enable
//   ADDSUB       out 1            0 add, 1 subtract (valid with GEN)
//   DONE         out 1            last step of the instruction
//   STEP         out 2            current step for debug
module proc_control_unit
  import proc_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int RSEL_W   = $clog2(NUM_REGS),
  parameter int IR_W     = 3 + 2 * RSEL_W
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                RUN,
  input  logic                ZFLAG,
  input  logic [IR_W-1:0]     IRLINE,
  output logic [NUM_REGS+1:0] MUXLINE,
  output logic [NUM_REGS-1:0] REGSELECTORS,
  output logic                IREN,
  output logic                AEN,
  output logic                GEN,
  output logic                ADDSUB,
  output logic                DONE,
  output logic [1:0]          STEP
);

  localparam int G_IDX   = MUX_G(NUM_REGS);
  localparam int DIN_IDX = MUX_DIN(NUM_REGS);

  step_t step;

  logic [2:0]          opcode;
  logic [RSEL_W-1:0]   xfield;
  logic [RSEL_W-1:0]   yfield;
  logic [NUM_REGS-1:0] xsel;
  logic [NUM_REGS-1:0] ysel;
  logic                is_arith;

  assign opcode   = IRLINE[IR_W-1 -: 3];
  assign xfield   = IRLINE[2*RSEL_W-1 -: RSEL_W];
  assign yfield   = IRLINE[RSEL_W-1:0];
  assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);

  // Decoders are disabled during reset so no register select can leak out.
  onehot_decoder #(.IN_W(RSEL_W)) u_xdec (
    .SEL    (xfield),
    .EN     (~RESET),
    .ONEHOT (xsel)
  );

  onehot_decoder #(.IN_W(RSEL_W)) u_ydec (
    .SEL    (yfield),
    .EN     (~RESET),
    .ONEHOT (ysel)
  );

  // Step register: only add/sub continue past T1.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      step <= T0;
    end else begin
      case (step)
        T0:      step <= RUN ? T1 : T0;
        T1:      step <= is_arith ? T2 : T0;
        T2:      step <= T3;
        T3:      step <= T0;
        default: step <= T0;
      endcase
    end
  end

  // Output decode of step and instruction; RESET overrides everything.
  always_comb begin
    MUXLINE      = '0;
    REGSELECTORS = '0;
    IREN         = 1'b0;
    AEN          = 1'b0;
    GEN          = 1'b0;
    ADDSUB       = 1'b0;
    DONE         = 1'b0;
    if (!RESET) begin
      case (step)
        T0: begin
          if (RUN) begin
            IREN             = 1'b1;
            MUXLINE[DIN_IDX] = 1'b1;
          end
        end
        T1: begin
          case (opcode)
            OP_MV: begin
              MUXLINE[NUM_REGS-1:0] = ysel;
              REGSELECTORS          = xsel;
              DONE                  = 1'b1;
            end
            OP_MVI: begin
              MUXLINE[DIN_IDX] = 1'b1;
              REGSELECTORS     = xsel;
              DONE             = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              MUXLINE[NUM_REGS-1:0] = xsel;
              AEN                   = 1'b1;
            end
            OP_MVNZ: begin
              // A set zero flag turns the move into a plain completion.
              if (!ZFLAG) begin
                MUXLINE[NUM_REGS-1:0] = ysel;
                REGSELECTORS          = xsel;
              end
              DONE = 1'b1;
            end
            default: DONE = 1'b1;
          endcase
        end
        T2: begin
          MUXLINE[NUM_REGS-1:0] = ysel;
          GEN                   = 1'b1;
          ADDSUB                = opcode[0];
        end
        T3: begin
          MUXLINE[G_IDX] = 1'b1;
          REGSELECTORS   = xsel;
          DONE           = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign STEP = RESET ? 2'b00 : step;

endmodule

// File: doc/proc_control_unit.md
# proc_control_unit

Parametrised control FSM for the simple bus-based processor. Sequences each instruction over up to four steps (T0–T3), driving the bus multiplexer, register load enables, A/G accumulator loads, and the adder/subtractor mode. Owns its own step counter, so no external counter is needed. Sits between the instruction register (IR) and the datapath (register file, A, G, ALU, bus mux); raises DONE on the last step of every instruction.

## Interface
Parameters:
- NUM_REGS, 8: number of general registers; power of two, 2..16.
- RSEL_W, $clog2(NUM_REGS): register-field width (derived; do not override).
- IR_W, 3+2*RSEL_W: instruction width. The format is opcode[IR_W-1 -: 3], X[2*RSEL_W-1 -: RSEL_W], Y[RSEL_W-1:0].

Ports:
- CLOCK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- RUN  in  1  start request; sampled only in T0.
- ZFLAG  in  1  high when the G register equals zero; used by mvnz.
- IRLINE  in  IR_W  IR contents; valid from T1 onward.
- MUXLINE  out  NUM_REGS+2  one-hot bus select: bits [NUM_REGS-1:0]=R0..Rn-1, bit NUM_REGS=G, bit NUM_REGS+1=DIN. All-zero means no driver.
- REGSELECTORS  out  NUM_REGS  one-hot load enable for R0..Rn-1.
- IREN  out  1  IR load enable.
- AEN  out  1  A register load enable.
- GEN  out  1  G register load enable.
- ADDSUB  out  1  0=add, 1=subtract; meaningful only while GEN=1.
- DONE  out  1  final step of the current instruction.
- STEP  out  2  current step (0..3), for debug.

## Operation
- Opcodes: 000 mv Rx←Ry; 001 mvi Rx←DIN; 010 add Rx←Rx+Ry; 011 sub Rx←Rx−Ry; 100 mvnz Rx←Ry if ZFLAG=0; 101–111 are reserved and execute as a NOP.
- The FSM has states T0, T1, T2, T3. Outputs are a combinational decode of the state and IRLINE. Every output not listed for a step is 0.
- T0:
  - RUN=0: stay in T0.
  - RUN=1: IREN=1, MUXLINE=DIN; go to T1.
- T1:
  - mv: MUXLINE=Ry, REGSELECTORS=Rx, DONE; go to T0.
  - mvi: MUXLINE=DIN, REGSELECTORS=Rx, DONE; go to T0.
  - add/sub: MUXLINE=Rx, AEN; go to T2.
  - mvnz with ZFLAG=0: behaves as mv.
  - mvnz with ZFLAG=1: DONE only; go to T0.
  - reserved: DONE only; go to T0.
- T2 (add/sub): MUXLINE=Ry, GEN, ADDSUB=opcode[0]; go to T3.
- T3 (add/sub): MUXLINE=G, REGSELECTORS=Rx, DONE; go to T0.
- X=Y is legal (for example, add R1,R1 doubles R1). No special case.
- DIN for mvi is the word that follows the instruction. The external sequencer presents it in T1.

## Timing
- Latency: mv, mvi, mvnz and NOP take 2 cycles (T0,T1); add/sub take 4 cycles (T0–T3). DONE is high for exactly 1 cycle.
- Back-to-back: when RUN stays high, a new fetch begins in the cycle after DONE.
- RUN is ignored outside T0. Dropping RUN mid-instruction does not abort the instruction.
- Reset: while RESET=1, all outputs are forced to 0. The state is T0 after the edge, so STEP=0 on the next cycle.
- Reset mid-operation: pending loads are discarded; no REGSELECTORS/GEN pulse occurs after the reset edge.
- ZFLAG is sampled combinationally in T1 only.

## Structure
- Shared package proc_pkg holds:
  - the opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MVNZ);
  - the step enum (T0..T3);
  - the mux-index helpers MUX_G(NUM_REGS)=NUM_REGS and MUX_DIN(NUM_REGS)=NUM_REGS+1.
- One sub-module: onehot_decoder #(IN_W), with EN. It is instantiated twice (X and Y fields) to produce the one-hot register selects.
- Target size: 150–250 lines including the decoder.

## Test plan
- NUM_REGS=8. RUN=1, IRLINE=9'b001_010_000 (mvi R2):
  - T0: IREN=1, MUXLINE=10'b10_00000000.
  - T1: MUXLINE=DIN, REGSELECTORS=8'b00000100, DONE=1.
- IRLINE=9'b011_011_101 (sub R3,R5):
  - T1: AEN with MUXLINE bit3.
  - T2: GEN=1, ADDSUB=1, MUXLINE bit5.
  - T3: MUXLINE bit8 (G), REGSELECTORS=8'b00001000, DONE.
- mvnz R1,R6 (9'b100_001_110):
  - ZFLAG=0: T1 MUXLINE bit6, REGSELECTORS=8'b00000010.
  - ZFLAG=1: T1 REGSELECTORS=0, DONE=1.
- Assert RESET in T2 of an add: outputs are 0 in the reset cycle, STEP=0 the next cycle, and no GEN/REGSELECTORS pulse follows.
- RUN=0 held for 5 cycles in T0: all outputs stay 0 and STEP=0. Then two consecutive mv instructions with RUN held high produce DONE on cycles 2 and 4.
- NUM_REGS=16 (IR_W=11): add R15,R0 drives MUXLINE bit15 then bit0, and REGSELECTORS=16'h8000 in T3.
